// File: rtl/srx_obs_sched.sv
// Observation-path scheduler: walks enabled antenna/band/path steps, holds each
// switch setting for a settle time, then requests a capture from the SRX engine.
module srx_obs_sched #(
  parameter logic [2:0] PARK_SEL = 3'd4,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_en,
  input  logic [3:0]       ant_mask,
  input  logic [1:0]       band_mask,
  input  logic             vswr_en,
  input  logic [CNT_W-1:0] settle_cyc,
  input  logic [CNT_W-1:0] timeout_cyc,
  input  logic             cap_done,
  output logic             cap_req,
  output logic             cap_err,
  output logic [2:0]       ant_sel,
  output logic             path_sel,
  output logic             band_sel,
  output logic             busy,
  output logic             round_done,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, NEXT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       step_idx, step_idx_nxt;   // {ant[1:0], band, path}
  logic [3:0]       sh_ant, sh_ant_nxt;
  logic [1:0]       sh_band, sh_band_nxt;
  logic             sh_vswr, sh_vswr_nxt;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             cap_req_nxt, cap_err_nxt, busy_nxt, round_done_nxt;
  logic [2:0]       ant_sel_nxt;
  logic             path_sel_nxt, band_sel_nxt;
  logic [7:0]       err_cnt_nxt;
  logic [4:0]       first_step, following_step;

  // Returns {found, index} of the lowest enabled step at or after 'start'.
  function automatic logic [4:0] find_step(input logic [4:0] start, input logic [3:0] am,
                                           input logic [1:0] bm, input logic ve);
    logic [4:0] res;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      logic [3:0] ii;
      ii = 4'(i);
      if (({1'b0, ii} >= start) && am[ii[3:2]] && bm[ii[1]] && (!ii[0] || ve))
        res = {1'b1, ii};
    end
    return res;
  endfunction

  assign first_step     = find_step(5'd0, ant_mask, band_mask, vswr_en);
  assign following_step = find_step({1'b0, step_idx} + 5'd1, sh_ant, sh_band, sh_vswr);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    step_idx_nxt   = step_idx;
    sh_ant_nxt     = sh_ant;
    sh_band_nxt    = sh_band;
    sh_vswr_nxt    = sh_vswr;
    settle_cnt_nxt = settle_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    cap_req_nxt    = cap_req;
    cap_err_nxt    = 1'b0;
    round_done_nxt = 1'b0;
    ant_sel_nxt    = ant_sel;
    path_sel_nxt   = path_sel;
    band_sel_nxt   = band_sel;
    err_cnt_nxt    = err_cnt;

    if (state != IDLE && !sched_en) begin
      // Abort beats done, timeout and advance: park silently, keep err_cnt.
      state_nxt    = IDLE;
      cap_req_nxt  = 1'b0;
      ant_sel_nxt  = PARK_SEL;
      path_sel_nxt = 1'b0;
      band_sel_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sched_en && (ant_mask != '0) && (band_mask != '0)) begin
            state_nxt      = SETTLE;
            sh_ant_nxt     = ant_mask;
            sh_band_nxt    = band_mask;
            sh_vswr_nxt    = vswr_en;
            step_idx_nxt   = first_step[3:0];
            ant_sel_nxt    = {1'b0, first_step[3:2]};
            band_sel_nxt   = first_step[1];
            path_sel_nxt   = first_step[0];
            settle_cnt_nxt = settle_cyc;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state_nxt   = CAPTURE;
            cap_req_nxt = 1'b1;
            tmo_cnt_nxt = timeout_cyc;
          end else begin
            settle_cnt_nxt = settle_cnt - CNT_W'(1);
          end
        end
        CAPTURE: begin
          // A zero-loaded timeout counter never reaches 1, which disables the timeout.
          if (cap_done) begin
            state_nxt   = NEXT;
            cap_req_nxt = 1'b0;
          end else if (tmo_cnt == CNT_W'(1)) begin
            state_nxt   = NEXT;
            cap_req_nxt = 1'b0;
            cap_err_nxt = 1'b1;
            if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
          end else if (tmo_cnt != '0) begin
            tmo_cnt_nxt = tmo_cnt - CNT_W'(1);
          end
        end
        NEXT: begin
          if (following_step[4]) begin
            state_nxt      = SETTLE;
            step_idx_nxt   = following_step[3:0];
            ant_sel_nxt    = {1'b0, following_step[3:2]};
            band_sel_nxt   = following_step[1];
            path_sel_nxt   = following_step[0];
            settle_cnt_nxt = settle_cyc;
          end else begin
            state_nxt      = IDLE;
            ant_sel_nxt    = PARK_SEL;
            path_sel_nxt   = 1'b0;
            band_sel_nxt   = 1'b0;
            round_done_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_idx   <= '0;
      sh_ant     <= '0;
      sh_band    <= '0;
      sh_vswr    <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      cap_req    <= 1'b0;
      cap_err    <= 1'b0;
      busy       <= 1'b0;
      round_done <= 1'b0;
      ant_sel    <= PARK_SEL;
      path_sel   <= 1'b0;
      band_sel   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      step_idx   <= step_idx_nxt;
      sh_ant     <= sh_ant_nxt;
      sh_band    <= sh_band_nxt;
      sh_vswr    <= sh_vswr_nxt;
      settle_cnt <= settle_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      cap_req    <= cap_req_nxt;
      cap_err    <= cap_err_nxt;
      busy       <= busy_nxt;
      round_done <= round_done_nxt;
      ant_sel    <= ant_sel_nxt;
      path_sel   <= path_sel_nxt;
      band_sel   <= band_sel_nxt;
      err_cnt    <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_srx_obs_sched.sv
// Directed self-checking bench for srx_obs_sched.
module tb_srx_obs_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sched_en = 1'b0;
  logic [3:0]  ant_mask = '0;
  logic [1:0]  band_mask = '0;
  logic        vswr_en = 1'b0;
  logic [15:0] settle_cyc = '0;
  logic [15:0] timeout_cyc = '0;
  logic        cap_done = 1'b0;
  logic        cap_req, cap_err, path_sel, band_sel, busy, round_done;
  logic [2:0]  ant_sel;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  srx_obs_sched #(.PARK_SEL(3'd4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .ant_mask(ant_mask),
    .band_mask(band_mask), .vswr_en(vswr_en), .settle_cyc(settle_cyc),
    .timeout_cyc(timeout_cyc), .cap_done(cap_done), .cap_req(cap_req),
    .cap_err(cap_err), .ant_sel(ant_sel), .path_sel(path_sel), .band_sel(band_sel),
    .busy(busy), .round_done(round_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_sel(input string tag, input logic [2:0] a, input logic b, input logic p);
    check({tag, "_ant"}, 32'(ant_sel), 32'(a));
    check({tag, "_band"}, 32'(band_sel), 32'(b));
    check({tag, "_path"}, 32'(path_sel), 32'(p));
  endtask

  task automatic abort_and_settle();
    sched_en = 1'b0;
    cap_done = 1'b0;
    tick(2);
  endtask

  initial begin
    int pulses;
    int sat_pulses;
    bit ok;

    // Reset state
    tick(2);
    check("rst_cap_req", 32'(cap_req), 0);
    check("rst_cap_err", 32'(cap_err), 0);
    check_sel("rst", 3'd4, 1'b0, 1'b0);
    check("rst_busy", 32'(busy), 0);
    check("rst_round_done", 32'(round_done), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    rst_n = 1'b1;
    tick(1);

    // Single step, settle 3, cap_done two cycles after cap_req
    ant_mask = 4'b0001; band_mask = 2'b01; vswr_en = 1'b0;
    settle_cyc = 16'd3; timeout_cyc = 16'd0; sched_en = 1'b1;
    tick(1);
    check_sel("t1_load", 3'd0, 1'b0, 1'b0);
    check("t1_busy", 32'(busy), 1);
    tick(3);
    check("t1_req_e3", 32'(cap_req), 0);
    tick(1);
    check("t1_req_e4", 32'(cap_req), 1);
    tick(1);
    check("t1_req_e5", 32'(cap_req), 1);
    cap_done = 1'b1;
    tick(1);
    check("t1_req_drop", 32'(cap_req), 0);
    check_sel("t1_hold", 3'd0, 1'b0, 1'b0);
    cap_done = 1'b0;
    tick(1);
    check("t1_round_done", 32'(round_done), 1);
    check_sel("t1_park", 3'd4, 1'b0, 1'b0);
    check("t1_busy_end", 32'(busy), 0);
    tick(1);
    check("t1_rd_low", 32'(round_done), 0);
    check("t1_restart", 32'(ant_sel), 0);
    check("t1_restart_busy", 32'(busy), 1);
    sched_en = 1'b0;
    tick(1);
    check("t1_abort_park", 32'(ant_sel), 4);
    check("t1_abort_busy", 32'(busy), 0);
    abort_and_settle();

    // settle 0, timeout 1: done coinciding with expiry wins; then a real timeout at 1
    settle_cyc = 16'd0; timeout_cyc = 16'd1; sched_en = 1'b1;
    tick(1);
    check("t4_load", 32'(ant_sel), 0);
    check("t4_req_low", 32'(cap_req), 0);
    tick(1);
    check("t4_req_rise", 32'(cap_req), 1);
    cap_done = 1'b1;
    tick(1);
    check("t4_req_drop", 32'(cap_req), 0);
    check("t4_no_err", 32'(cap_err), 0);
    check("t4_err_cnt", 32'(err_cnt), 0);
    cap_done = 1'b0;
    tick(1);
    check("t4_round_done", 32'(round_done), 1);
    tick(1);
    check("t4_reload", 32'(ant_sel), 0);
    tick(1);
    check("t4_req2", 32'(cap_req), 1);
    tick(1);
    check("t4_tmo_err", 32'(cap_err), 1);
    check("t4_tmo_req", 32'(cap_req), 0);
    exp_err = 1;
    check("t4_tmo_cnt", 32'(err_cnt), 32'(exp_err));
    tick(1);
    check("t4_err_pulse_end", 32'(cap_err), 0);
    abort_and_settle();

    // Eight-step walk, cap_done held high, mask change mid-round
    ant_mask = 4'b1010; band_mask = 2'b11; vswr_en = 1'b1;
    timeout_cyc = 16'd0; cap_done = 1'b1; sched_en = 1'b1;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] ea;
      logic [2:0] kk;
      kk = 3'(k);
      ea = (k < 4) ? 3'd1 : 3'd3;
      check_sel($sformatf("t2_step%0d", k), ea, kk[1], kk[0]);
      check($sformatf("t2_rd%0d", k), 32'(round_done), 0);
      check($sformatf("t2_req_lo%0d", k), 32'(cap_req), 0);
      if (k == 0) ant_mask = 4'b0001;
      tick(1);
      check($sformatf("t2_req_hi%0d", k), 32'(cap_req), 1);
      check($sformatf("t2_hold%0d", k), 32'(ant_sel), 32'(ea));
      tick(1);
      check($sformatf("t2_req_drop%0d", k), 32'(cap_req), 0);
      tick(1);
    end
    check("t2_round_done", 32'(round_done), 1);
    check("t2_park", 32'(ant_sel), 4);
    check("t2_busy", 32'(busy), 0);
    tick(1);
    check("t2_rd_once", 32'(round_done), 0);
    check_sel("t2_new_round", 3'd0, 1'b0, 1'b0);
    check("t2_new_busy", 32'(busy), 1);
    abort_and_settle();

    // Abort while cap_req is high; later cap_done ignored
    ant_mask = 4'b0100; band_mask = 2'b10; vswr_en = 1'b0;
    settle_cyc = 16'd2; timeout_cyc = 16'd0; sched_en = 1'b1;
    tick(1);
    check_sel("t5_load", 3'd2, 1'b1, 1'b0);
    tick(3);
    check("t5_req", 32'(cap_req), 1);
    sched_en = 1'b0;
    tick(1);
    check("t5_req_off", 32'(cap_req), 0);
    check_sel("t5_park", 3'd4, 1'b0, 1'b0);
    check("t5_busy", 32'(busy), 0);
    check("t5_no_rd", 32'(round_done), 0);
    check("t5_no_err", 32'(cap_err), 0);
    cap_done = 1'b1;
    tick(2);
    check("t5_ignored_req", 32'(cap_req), 0);
    check("t5_ignored_busy", 32'(busy), 0);
    check("t5_err_kept", 32'(err_cnt), 32'(exp_err));
    cap_done = 1'b0;

    // Timeout 5, no cap_done: pulse timing, advance, saturation
    ant_mask = 4'b0001; band_mask = 2'b01; vswr_en = 1'b1;
    settle_cyc = 16'd0; timeout_cyc = 16'd5; sched_en = 1'b1;
    tick(1);
    check_sel("t3_load", 3'd0, 1'b0, 1'b0);
    tick(1);
    check("t3_req_rise", 32'(cap_req), 1);
    tick(4);
    check("t3_req_r4", 32'(cap_req), 1);
    check("t3_err_r4", 32'(cap_err), 0);
    tick(1);
    exp_err++;
    check("t3_err_r5", 32'(cap_err), 1);
    check("t3_req_r5", 32'(cap_req), 0);
    check("t3_cnt_r5", 32'(err_cnt), 32'(exp_err));
    tick(1);
    check("t3_err_end", 32'(cap_err), 0);
    check_sel("t3_advance", 3'd0, 1'b0, 1'b1);
    pulses = 0; sat_pulses = 0; ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if (cap_err) begin
        pulses++;
        if (exp_err == 255) sat_pulses++;
        else exp_err++;
        check($sformatf("t3_cnt_p%0d", pulses), 32'(err_cnt), 32'(exp_err));
        if (sat_pulses >= 3) begin
          ok = 1'b1;
          break;
        end
      end
    end
    check("t3_saturate_reached", 32'(ok), 1);
    check("t3_err_sat", 32'(err_cnt), 255);
    abort_and_settle();

    // Empty masks keep the FSM idle
    ant_mask = 4'b0000; band_mask = 2'b11; sched_en = 1'b1;
    tick(3);
    check("t6_busy_ant0", 32'(busy), 0);
    check("t6_park_ant0", 32'(ant_sel), 4);
    ant_mask = 4'b1111; band_mask = 2'b00;
    tick(2);
    check("t6_busy_band0", 32'(busy), 0);
    check("t6_req_band0", 32'(cap_req), 0);
    sched_en = 1'b0;
    tick(1);

    // Asynchronous reset mid-SETTLE
    ant_mask = 4'b0001; band_mask = 2'b01; settle_cyc = 16'd10; sched_en = 1'b1;
    tick(1);
    check("t7_busy", 32'(busy), 1);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check_sel("t7_rst", 3'd4, 1'b0, 1'b0);
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_req", 32'(cap_req), 0);
    check("t7_rst_err_cnt", 32'(err_cnt), 0);
    check("t7_rst_cap_err", 32'(cap_err), 0);
    check("t7_rst_rd", 32'(round_done), 0);
    sched_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
